// File: rtl/hazard_pkg.sv
// Purpose: shared types and helpers for the pipeline hazard controller.
// Latency: n/a (package); fwd_sel is purely combinational.
// Backpressure: n/a.
package hazard_pkg;

  // Operand select codes for the E-stage forwarding muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // E-stage forward select for one source register. The M-stage producer is
  // younger than the W-stage one, so it wins. Register 0 never matches.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       rw_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic [4:0] wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && rw_m && wr_m == src) begin
      sel = FWD_MEM;
    end else if (src != 5'd0 && rw_w && wr_w == src) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Purpose: bundles the pipeline-side signals seen by the hazard controller.
// Latency: n/a (wires only).
// Backpressure: stall_F/stall_D/flush_E are the pipeline's hold/clear controls.
// Ports: master = pipeline (drives register numbers and stage flags, receives
//        stall/forward controls); slave = hazard_unit.
interface hazard_unit_if;
  logic [4:0] rs_D, rt_D, rs_E, rt_E;
  logic [4:0] writereg_E, writereg_M, writereg_W;
  logic       regwrite_E, regwrite_M, regwrite_W;
  logic       memtoreg_E, memtoreg_M;
  logic       branch_D, md_D, md_start_E, md_op_E;
  logic       stall_F, stall_D, flush_E;
  logic       forwardA_D, forwardB_D;
  logic [1:0] forwardA_E, forwardB_E;
  logic       md_busy, md_done;

  modport master (
    output rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W,
           regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M,
           branch_D, md_D, md_start_E, md_op_E,
    input  stall_F, stall_D, flush_E, forwardA_D, forwardB_D,
           forwardA_E, forwardB_E, md_busy, md_done
  );

  modport slave (
    input  rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W,
           regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M,
           branch_D, md_D, md_start_E, md_op_E,
    output stall_F, stall_D, flush_E, forwardA_D, forwardB_D,
           forwardA_E, forwardB_E, md_busy, md_done
  );
endinterface

// File: rtl/md_tracker.sv
// Purpose: counts multiply/divide execution cycles so HI/LO consumers can wait.
// Latency: busy from the cycle after md_start is sampled, for MULT/DIV_CYCLES.
// Backpressure: none; md_start while busy is illegal and is ignored.
// Ports: clk, reset (async active-low), md_start/md_op in; md_busy/md_done out.
module md_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_op,
  output logic md_busy,
  output logic md_done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // A single-cycle unit would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          cnt_d   = md_op ? DIV_LOAD : MULT_LOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A start here is a protocol violation: no reload, just keep counting.
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);
  assign md_done = done;

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(md_start && state_q == MD_BUSY)
  ) else $error("md_start asserted while multiply/divide unit busy");

endmodule

// File: rtl/hazard_unit.sv
// Purpose: stall, flush and forwarding control for the five-stage MIPS pipeline.
// Latency: all controls combinational (zero cycles) from inputs and tracker state.
// Backpressure: any hazard holds F and D and bubbles E via stall_F/stall_D/flush_E.
// Ports: clk, reset (async active-low), hif (slave: stage register numbers and
//        flags in; stalls, forward selects, md_busy/md_done out).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_unit_if.slave       hif
);

  logic md_busy, md_done;
  logic lwstall, brstall, mdstall, stall;
  logic e_hits_d, m_hits_d;

  md_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_tracker (
    .clk      (clk),
    .reset    (reset),
    .md_start (hif.md_start_E),
    .md_op    (hif.md_op_E),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  always_comb begin
    // Destination of E or M matches a nonzero D-stage source.
    e_hits_d = (hif.rs_D != 5'd0 && hif.writereg_E == hif.rs_D) ||
               (hif.rt_D != 5'd0 && hif.writereg_E == hif.rt_D);
    m_hits_d = (hif.rs_D != 5'd0 && hif.writereg_M == hif.rs_D) ||
               (hif.rt_D != 5'd0 && hif.writereg_M == hif.rt_D);

    lwstall = hif.memtoreg_E && hif.regwrite_E && e_hits_d;
    // Branches compare in D, so an ALU result still in E or a load in M
    // cannot be forwarded in time.
    brstall = hif.branch_D && ((hif.regwrite_E && e_hits_d) ||
                               (hif.memtoreg_M && m_hits_d));
    // md_start_E covers the cycle before the tracker has gone busy.
    mdstall = hif.md_D && (md_busy || hif.md_start_E);
    stall   = lwstall || brstall || mdstall;
  end

  assign hif.stall_F    = stall;
  assign hif.stall_D    = stall;
  assign hif.flush_E    = stall;
  assign hif.forwardA_D = hif.regwrite_M && hif.rs_D != 5'd0 && hif.writereg_M == hif.rs_D;
  assign hif.forwardB_D = hif.regwrite_M && hif.rt_D != 5'd0 && hif.writereg_M == hif.rt_D;
  assign hif.forwardA_E = fwd_sel(hif.rs_E, hif.regwrite_M, hif.writereg_M,
                                  hif.regwrite_W, hif.writereg_W);
  assign hif.forwardB_E = fwd_sel(hif.rt_E, hif.regwrite_M, hif.writereg_M,
                                  hif.regwrite_W, hif.writereg_W);
  assign hif.md_busy    = md_busy;
  assign hif.md_done    = md_done;

endmodule
